// File: rtl/spi_cmd_responder.sv
`default_nettype none
// ============================================================================
// spi_cmd_responder : SPI mode-0 slave decoding a command byte and data bytes
// Revision          : 1.0
// ============================================================================
module spi_cmd_responder #(
    parameter int MAX_BYTES   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic       spi_slave_sck,
    input  logic       spi_slave_mosi,
    input  logic       spi_slave_ncs,
    output logic       spi_slave_miso,
    input  logic [7:0] status,
    output logic [7:0] cmd,
    output logic       cmd_valid,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic [4:0] byte_idx,
    output logic       tx_req,
    input  logic [7:0] tx_data,
    output logic       xfer_done,
    output logic       frame_err
);
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        CMD        = 2'd1,
        DATA       = 2'd2,
        WAIT_DESEL = 2'd3
    } state_t;

    localparam int                    c_settle_w   = $clog2(SYNC_STAGES + 1);
    localparam logic [c_settle_w-1:0] c_settle_cnt = c_settle_w'(SYNC_STAGES);
    localparam logic [c_settle_w-1:0] c_settle_one = c_settle_w'(1);
    localparam logic [4:0]            c_max_idx    = 5'(MAX_BYTES);

    logic [SYNC_STAGES-1:0] sck_sync_q, mosi_sync_q, ncs_sync_q;
    logic sck_s, mosi_s, ncs_s;
    logic sck_prev_q, ncs_prev_q;
    logic sck_rise, sck_fall, ncs_rise, ncs_fall;

    generate
        if (SYNC_STAGES == 1) begin : g_sync_single
            always_ff @(posedge sysclk or negedge rst_n) begin
                if (!rst_n) begin
                    sck_sync_q  <= '0;
                    mosi_sync_q <= '0;
                    ncs_sync_q  <= '1;
                end else begin
                    sck_sync_q  <= spi_slave_sck;
                    mosi_sync_q <= spi_slave_mosi;
                    ncs_sync_q  <= spi_slave_ncs;
                end
            end
        end else begin : g_sync_chain
            always_ff @(posedge sysclk or negedge rst_n) begin
                if (!rst_n) begin
                    sck_sync_q  <= '0;
                    mosi_sync_q <= '0;
                    ncs_sync_q  <= '1;
                end else begin
                    sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_slave_sck};
                    mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_slave_mosi};
                    ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], spi_slave_ncs};
                end
            end
        end
    endgenerate

    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    assign ncs_s  = ncs_sync_q[SYNC_STAGES-1];

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            sck_prev_q <= 1'b0;
            ncs_prev_q <= 1'b1;
        end else begin
            sck_prev_q <= sck_s;
            ncs_prev_q <= ncs_s;
        end
    end

    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign ncs_rise = ncs_s & ~ncs_prev_q;
    assign ncs_fall = ~ncs_s & ncs_prev_q;

    state_t state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] tx_hold_q;
    logic       req_dly_q;
    logic [7:0] cmd_q, cmd_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic [4:0] byte_idx_q, byte_idx_d;
    logic [4:0] data_cnt_q, data_cnt_d;
    logic       cmd_valid_q, cmd_valid_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_req_q, tx_req_d;
    logic       xfer_done_q, xfer_done_d;
    logic       frame_err_q, frame_err_d;
    logic       quiet_q, quiet_d;
    logic       ready_q, ready_d;
    logic [c_settle_w-1:0] settle_q, settle_d;
    logic [7:0] rx_byte;

    assign rx_byte = {rx_shift_q[6:0], mosi_s};

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            cmd_q       <= '0;
            rx_data_q   <= '0;
            byte_idx_q  <= '0;
            data_cnt_q  <= '0;
            cmd_valid_q <= 1'b0;
            rx_valid_q  <= 1'b0;
            tx_req_q    <= 1'b0;
            xfer_done_q <= 1'b0;
            frame_err_q <= 1'b0;
            quiet_q     <= 1'b0;
            ready_q     <= 1'b0;
            settle_q    <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            cmd_q       <= cmd_d;
            rx_data_q   <= rx_data_d;
            byte_idx_q  <= byte_idx_d;
            data_cnt_q  <= data_cnt_d;
            cmd_valid_q <= cmd_valid_d;
            rx_valid_q  <= rx_valid_d;
            tx_req_q    <= tx_req_d;
            xfer_done_q <= xfer_done_d;
            frame_err_q <= frame_err_d;
            quiet_q     <= quiet_d;
            ready_q     <= ready_d;
            settle_q    <= settle_d;
        end
    end

    // tx_data is captured on the second rising edge after tx_req asserts
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            req_dly_q <= 1'b0;
            tx_hold_q <= '0;
        end else begin
            req_dly_q <= tx_req_q;
            if (req_dly_q) begin
                tx_hold_q <= tx_data;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        cmd_d       = cmd_q;
        rx_data_d   = rx_data_q;
        byte_idx_d  = byte_idx_q;
        data_cnt_d  = data_cnt_q;
        quiet_d     = quiet_q;
        ready_d     = ready_q;
        settle_d    = settle_q;
        cmd_valid_d = 1'b0;
        rx_valid_d  = 1'b0;
        tx_req_d    = 1'b0;
        xfer_done_d = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                // After reset, wait for the synchronizers to fill before trusting ncs
                if (!ready_q) begin
                    if (settle_q == c_settle_cnt) begin
                        ready_d = 1'b1;
                        if (!ncs_s) begin
                            state_d = WAIT_DESEL;
                            quiet_d = 1'b1;
                        end
                    end else begin
                        settle_d = settle_q + c_settle_one;
                    end
                end else if (ncs_fall) begin
                    state_d    = CMD;
                    bit_cnt_d  = '0;
                    rx_shift_d = '0;
                    data_cnt_d = '0;
                    tx_shift_d = status;
                end
            end

            CMD, DATA: begin
                if (ncs_rise) begin
                    xfer_done_d = 1'b1;
                    frame_err_d = (bit_cnt_q != 3'd0);
                    state_d     = IDLE;
                    bit_cnt_d   = '0;
                    tx_shift_d  = '0;
                end else begin
                    if (sck_rise) begin
                        rx_shift_d = rx_byte;
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (state_q == CMD) begin
                                cmd_d       = rx_byte;
                                cmd_valid_d = 1'b1;
                                tx_req_d    = 1'b1;
                                data_cnt_d  = '0;
                                state_d     = DATA;
                            end else if (data_cnt_q == c_max_idx) begin
                                frame_err_d = 1'b1;
                                tx_shift_d  = '0;
                                state_d     = WAIT_DESEL;
                            end else begin
                                rx_data_d   = rx_byte;
                                rx_valid_d  = 1'b1;
                                tx_req_d    = 1'b1;
                                byte_idx_d  = data_cnt_q;
                                data_cnt_d  = data_cnt_q + 5'd1;
                            end
                        end
                    end
                    // A fall with the bit count wrapped to 0 is the 8th fall of a byte
                    if (sck_fall) begin
                        tx_shift_d = (bit_cnt_q == 3'd0) ? tx_hold_q : {tx_shift_q[6:0], 1'b0};
                    end
                end
            end

            WAIT_DESEL: begin
                if (ncs_rise) begin
                    xfer_done_d = ~quiet_q;
                    quiet_d     = 1'b0;
                    bit_cnt_d   = '0;
                    state_d     = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign spi_slave_miso = tx_shift_q[7] & ~spi_slave_ncs & ((state_q == CMD) || (state_q == DATA));
    assign cmd       = cmd_q;
    assign cmd_valid = cmd_valid_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign byte_idx  = byte_idx_q;
    assign tx_req    = tx_req_q;
    assign xfer_done = xfer_done_q;
    assign frame_err = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_cmd_responder.sv
`default_nettype none
// ============================================================================
// tb_spi_cmd_responder : directed SPI master with event/miso scoreboards
// Revision             : 1.0
// ============================================================================
module tb_spi_cmd_responder;
    localparam int MAX_BYTES = 16;

    localparam logic [2:0] K_CMD  = 3'd0;
    localparam logic [2:0] K_RX   = 3'd1;
    localparam logic [2:0] K_ERR  = 3'd2;
    localparam logic [2:0] K_DONE = 3'd3;
    localparam logic [2:0] K_NONE = 3'd7;

    typedef struct packed {
        logic [2:0] kind;
        logic [7:0] data;
        logic [4:0] idx;
    } ev_t;

    logic       sysclk;
    logic       rst_n;
    logic       spi_sck;
    logic       spi_mosi;
    logic       spi_ncs;
    logic       spi_miso;
    logic [7:0] status;
    logic [7:0] cmd;
    logic       cmd_valid;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [4:0] byte_idx;
    logic       tx_req;
    logic [7:0] tx_data;
    logic       xfer_done;
    logic       frame_err;

    int vectors     = 0;
    int miscompares = 0;

    ev_t        ev_q[$];
    logic [7:0] miso_exp[$];
    logic [7:0] fb[$];
    logic [7:0] cap[$];
    logic [7:0] cap_a[$];
    logic [7:0] tx_seed;

    spi_cmd_responder #(.MAX_BYTES(MAX_BYTES), .SYNC_STAGES(2)) dut (
        .sysclk         (sysclk),
        .rst_n          (rst_n),
        .spi_slave_sck  (spi_sck),
        .spi_slave_mosi (spi_mosi),
        .spi_slave_ncs  (spi_ncs),
        .spi_slave_miso (spi_miso),
        .status         (status),
        .cmd            (cmd),
        .cmd_valid      (cmd_valid),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .byte_idx       (byte_idx),
        .tx_req         (tx_req),
        .tx_data        (tx_data),
        .xfer_done      (xfer_done),
        .frame_err      (frame_err)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_ev(input ev_t got);
        ev_t exp;
        vectors++;
        exp = (ev_q.size() != 0) ? ev_q.pop_front() : {K_NONE, 8'h00, 5'd0};
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL event observed kind=%0d data=%0h idx=%0d expected kind=%0d data=%0h idx=%0d",
                   got.kind, got.data, got.idx, exp.kind, exp.data, exp.idx);
        end
    endtask

    // Output-pulse monitor, sampled mid-cycle
    always @(negedge sysclk) begin
        if (cmd_valid === 1'b1) check_ev({K_CMD, cmd, 5'd0});
        if (rx_valid === 1'b1)  check_ev({K_RX, rx_data, byte_idx});
        if (frame_err === 1'b1) check_ev({K_ERR, 8'h00, 5'd0});
        if (xfer_done === 1'b1) check_ev({K_DONE, 8'h00, 5'd0});
    end

    // Upstream responder: only the value driven in the cycle after tx_req is valid
    initial begin
        tx_data = 8'h00;
        tx_seed = 8'h10;
        forever begin
            @(negedge sysclk);
            if (tx_req === 1'b1) begin
                tx_data = ~tx_seed;
                @(negedge sysclk);
                tx_data = tx_seed;
                miso_exp.push_back(tx_seed);
                @(negedge sysclk);
                tx_data = tx_seed ^ 8'h5A;
                tx_seed = tx_seed + 8'h3B;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic send_bits(input logic [7:0] b, input int n, input int hp, output logic [7:0] got);
        got = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            spi_mosi = b[i];
            repeat (hp) @(negedge sysclk);
            got = {got[6:0], spi_miso};
            spi_sck = 1'b1;
            repeat (hp) @(negedge sysclk);
            spi_sck = 1'b0;
        end
    endtask

    // Drives fb as one frame; cut_bits > 0 appends a truncated trailing byte
    task automatic run_frame(input int hp, input int cut_bits);
        logic [7:0] got;
        logic [7:0] exp;
        miso_exp.delete();
        cap.delete();
        miso_exp.push_back(status);
        spi_ncs = 1'b0;
        repeat (hp + 4) @(negedge sysclk);
        for (int k = 0; k < fb.size(); k++) begin
            if (k == 0)                   ev_q.push_back({K_CMD, fb[0], 5'd0});
            else if (k - 1 < MAX_BYTES)   ev_q.push_back({K_RX, fb[k], 5'(k - 1)});
            else if (k - 1 == MAX_BYTES)  ev_q.push_back({K_ERR, 8'h00, 5'd0});
            send_bits(fb[k], 8, hp, got);
            cap.push_back(got);
            if (k - 1 <= MAX_BYTES) exp = (miso_exp.size() != 0) ? miso_exp.pop_front() : 8'hxx;
            else                    exp = 8'h00;
            check($sformatf("miso_byte%0d", k), {24'd0, got}, {24'd0, exp});
        end
        if (cut_bits > 0) begin
            send_bits(8'hC3, cut_bits, hp, got);
            ev_q.push_back({K_ERR, 8'h00, 5'd0});
        end
        ev_q.push_back({K_DONE, 8'h00, 5'd0});
        repeat (hp) @(negedge sysclk);
        spi_ncs = 1'b1;
        #1;
        check("miso_deselected", {31'd0, spi_miso}, 32'd0);
        repeat (hp + 10) @(negedge sysclk);
        check("events_drained", ev_q.size(), 32'd0);
    endtask

    initial begin
        logic [7:0] got;
        rst_n    = 1'b0;
        spi_sck  = 1'b0;
        spi_mosi = 1'b0;
        spi_ncs  = 1'b1;
        status   = 8'hA5;
        repeat (4) @(negedge sysclk);
        check("reset_outputs", {5'd0, cmd, rx_data, byte_idx, cmd_valid, rx_valid, tx_req,
                                xfer_done, frame_err, spi_miso}, 32'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge sysclk);
        check("idle_outputs", {5'd0, cmd, rx_data, byte_idx, cmd_valid, rx_valid, tx_req,
                               xfer_done, frame_err, spi_miso}, 32'd0);

        // Read command, status A5 returned first, then upstream bytes
        fb = '{8'h92, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_frame(4, 0);
        check("cmd_read", {24'd0, cmd}, 32'h92);

        // Write command with distinct data
        status = 8'h3C;
        fb = '{8'h12, 8'h08, 8'h0A, 8'h02, 8'h05, 8'h03};
        run_frame(6, 0);
        check("cmd_write", {24'd0, cmd}, 32'h12);
        check("last_rx_data", {24'd0, rx_data}, 32'h03);
        check("last_byte_idx", {27'd0, byte_idx}, 32'd4);

        // Overflow: 17 data bytes plus one more to observe miso held at 0
        fb.delete();
        fb.push_back(8'h80);
        for (int i = 0; i < MAX_BYTES + 2; i++) fb.push_back(8'(8'h40 + i));
        run_frame(5, 0);

        // Truncated third byte, then a clean frame
        fb = '{8'hC1, 8'h11, 8'h22};
        run_frame(4, 3);
        check("partial_rx_kept", {24'd0, rx_data}, 32'h22);
        fb = '{8'h41, 8'h77};
        run_frame(4, 0);
        check("after_partial_cmd", {24'd0, cmd}, 32'h41);

        // Reset pulse in the middle of a frame
        miso_exp.delete();
        ev_q.push_back({K_CMD, 8'h33, 5'd0});
        spi_ncs = 1'b0;
        repeat (8) @(negedge sysclk);
        send_bits(8'h33, 8, 4, got);
        send_bits(8'hF0, 4, 4, got);
        rst_n = 1'b0;
        repeat (3) @(negedge sysclk);
        check("midreset_outputs", {5'd0, cmd, rx_data, byte_idx, cmd_valid, rx_valid, tx_req,
                                   xfer_done, frame_err, spi_miso}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge sysclk);
        send_bits(8'h5A, 8, 4, got);
        send_bits(8'hA5, 8, 4, got);
        check("ignored_miso", {24'd0, got}, 32'd0);
        spi_ncs = 1'b1;
        repeat (14) @(negedge sysclk);
        check("ignored_frame_quiet", ev_q.size(), 32'd0);
        check("ignored_cmd_zero", {24'd0, cmd}, 32'd0);
        fb = '{8'hB0, 8'h00};
        run_frame(4, 0);
        check("post_reset_cmd", {24'd0, cmd}, 32'hB0);

        // Same frame at two sck rates must give identical miso streams
        fb = '{8'h12, 8'h08, 8'h0A, 8'h02, 8'h05, 8'h03};
        tx_seed = 8'h10;
        run_frame(4, 0);
        cap_a = cap;
        tx_seed = 8'h10;
        run_frame(8, 0);
        check("rate_len", cap.size(), cap_a.size());
        for (int i = 0; i < cap.size() && i < cap_a.size(); i++)
            check($sformatf("rate_byte%0d", i), {24'd0, cap[i]}, {24'd0, cap_a[i]});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_cmd_responder.md
SPI_CMD_RESPONDER -- requirements
Module: spi_cmd_responder

Interface
REQ-001 SHALL have parameter MAX_BYTES, default 16, giving the number of data bytes accepted after the command byte.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth on sck/mosi/ncs.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port sysclk  in  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port spi_slave_sck  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-007 SHALL have port spi_slave_mosi  in  1  SPI data in, MSB first.
REQ-008 SHALL have port spi_slave_ncs  in  1  active-low chip select.
REQ-009 SHALL have port spi_slave_miso  out  1  SPI data out, MSB first.
REQ-010 SHALL have port status  in  8  byte shifted out during the command byte.
REQ-011 SHALL have port cmd  out  8  last received command byte; bit7=1 read, bit7=0 write, bits6:0 address.
REQ-012 SHALL have port cmd_valid  out  1  one-cycle pulse when cmd updates.
REQ-013 SHALL have port rx_data  out  8  last received data byte.
REQ-014 SHALL have port rx_valid  out  1  one-cycle pulse when rx_data updates.
REQ-015 SHALL have port byte_idx  out  5  index of the data byte in rx_data, 0-based after the command.
REQ-016 SHALL have port tx_req  out  1  one-cycle pulse requesting the next transmit byte.
REQ-017 SHALL have port tx_data  in  8  transmit byte, sampled 2 cycles after tx_req.
REQ-018 SHALL have port xfer_done  out  1  one-cycle pulse on ncs deassertion ending a frame.
REQ-019 SHALL have port frame_err  out  1  one-cycle pulse when ncs rises with a partial byte, or when a byte beyond MAX_BYTES is received.

Function
REQ-020 SHALL pass sck, mosi and ncs through SYNC_STAGES flops, then detect sck rise and fall edges and ncs fall and rise edges on the synchronized signals.
REQ-021 SHALL operate correctly for sck half-periods of at least 4 sysclk cycles.
REQ-022 SHALL implement the states IDLE, CMD, DATA and WAIT_DESEL.
REQ-023 SHALL, in IDLE on ncs fall, enter CMD, clear the bit counter, load status into the tx shifter, and drive status[7] on miso.
REQ-024 SHALL sample mosi on each synchronized sck rise and shift out the next miso bit on each sck fall.
REQ-025 SHALL, on the 8th sck rise in CMD: update cmd, pulse cmd_valid, pulse tx_req, and enter DATA with byte_idx=0.
REQ-026 SHALL, on the 8th sck rise in DATA: update rx_data, pulse rx_valid with the current byte_idx, pulse tx_req, then increment byte_idx.
REQ-027 SHALL latch tx_data exactly 2 sysclk cycles after each tx_req and load it into the tx shifter on the following 8th sck fall, so its MSB is on miso before the next byte's first rise.
REQ-028 SHALL pulse tx_req and rx_valid for both read and write commands; interpreting the stream is up to the upstream logic.
REQ-029 SHALL, when a byte completes with byte_idx = MAX_BYTES: suppress rx_valid and tx_req, pulse frame_err, enter WAIT_DESEL, and drive miso to 0.
REQ-030 SHALL, on ncs rise in CMD/DATA with bit count 0: pulse xfer_done and return to IDLE.
REQ-031 SHALL, on ncs rise with bit count 1-7: pulse frame_err and xfer_done, discard the partial byte, and return to IDLE.
REQ-032 SHALL, on ncs rise in WAIT_DESEL: pulse xfer_done and return to IDLE.
REQ-033 SHALL drive spi_slave_miso to 0 while ncs is high.
REQ-034 SHALL ignore sck edges while ncs is high.
REQ-035 SHALL give priority to ncs rise when an sck rise and an ncs rise are detected in the same cycle.

Reset
REQ-036 SHALL, while rst_n is low, force: state IDLE, cmd=0, rx_data=0, byte_idx=0, all pulses 0, spi_slave_miso=0, counters and shifters 0, synchronizer flops to ncs=1, sck=0, mosi=0.
REQ-037 SHALL, if ncs is low when rst_n rises, enter WAIT_DESEL and ignore the frame until ncs rises; that ncs rise produces no xfer_done.

Verification
REQ-038 SHALL verify: status=0xA5, frame 0x92,00,00,00,00,00 -> miso returns A5 then tx_data bytes; cmd=0x92; five rx_valid with byte_idx 0-4; one xfer_done.
REQ-039 SHALL verify: write frame 0x12,08,0A,02,05,03 -> rx_data sequence 08,0A,02,05,03 at byte_idx 0-4; cmd_valid once with cmd=0x12.
REQ-040 SHALL verify: 0x80 followed by 17 data bytes at MAX_BYTES=16 -> 16 rx_valid, frame_err on the 17th byte, miso=0 afterwards, xfer_done at ncs rise.
REQ-041 SHALL verify: ncs raised after 3 bits of byte 2 -> frame_err and xfer_done pulse, no rx_valid for that byte, next frame decodes normally.
REQ-042 SHALL verify: rst_n pulsed low mid-frame -> all outputs 0; the remainder of the frame is ignored; the next full frame 0xB0,00 decodes with cmd=0xB0.
REQ-043 SHALL verify: sck half-period of 4 cycles versus 8 cycles -> identical decoded bytes and miso bit streams.
